// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } arb_st_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_own_t;

  localparam logic [1:0]  WE_LOAD   = 2'b00;
  localparam logic [1:0]  WE_WORD   = 2'b01;
  localparam logic [1:0]  WE_HALF   = 2'b10;
  localparam logic [1:0]  WE_BYTE   = 2'b11;
  localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;

  // Store data trimmed to the width the store type actually writes.
  function automatic logic [31:0] store_data(input logic [1:0] we, input logic [31:0] wd);
    logic [31:0] res;
    case (we)
      WE_WORD: res = wd;
      WE_HALF: res = {16'h0000, wd[15:0]};
      WE_BYTE: res = {24'h00_0000, wd[7:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between fetch and data requesters with a bounded D burst.
module mem_arb_pick
  import mips_mem_pkg::*;
#(
  parameter int D_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_en,
  output logic gnt_i,
  output logic gnt_d
);

  localparam int BW = $clog2(D_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(D_BURST);

  logic [BW-1:0] burst_r;
  logic          i_turn_s;

  // Grant decision: D wins unless I has waited out a full burst.
  always_comb begin
    gnt_i    = 1'b0;
    gnt_d    = 1'b0;
    i_turn_s = i_req && (burst_r == BURST_MAX);
    if (grant_en) begin
      if (d_req && !i_turn_s) begin
        gnt_d = 1'b1;
      end else if (i_req) begin
        gnt_i = 1'b1;
      end else begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
      end
    end else begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
    end
  end

  // Saturating count of D grants made while I was kept waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      burst_r <= '0;
    end else if (gnt_i) begin
      burst_r <= '0;
    end else if (gnt_d) begin
      if (!i_req) begin
        burst_r <= '0;
      end else if (burst_r != BURST_MAX) begin
        burst_r <= burst_r + BW'(1);
      end else begin
        burst_r <= burst_r;
      end
    end else begin
      burst_r <= burst_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// with per-requester stalls and a watchdog that aborts hung accesses.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int D_BURST = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [31:0]   i_rdata,
  output logic          istall,
  input  logic          d_req,
  input  logic [1:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ready,
  output logic [31:0]   d_rdata,
  output logic          dstall,
  output logic          m_req,
  output logic [1:0]    m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  input  logic          m_ack,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  arb_st_t       state_r, state_s;
  arb_own_t      owner_r;
  logic [TW-1:0] tmo_cnt_r;
  logic          gnt_i_s, gnt_d_s, grant_en_s, tmo_s;
  logic          i_ready_r, d_ready_r, err_r, m_req_r;
  logic [31:0]   i_rdata_r, d_rdata_r, m_wdata_r;
  logic [1:0]    m_we_r;
  logic [AW-1:0] m_addr_r;

  assign grant_en_s = (state_r == ST_IDLE);

  mem_arb_pick #(
    .D_BURST (D_BURST)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .d_req    (d_req),
    .grant_en (grant_en_s),
    .gnt_i    (gnt_i_s),
    .gnt_d    (gnt_d_s)
  );

  // Watchdog expiry; a same-cycle m_ack takes precedence.
  assign tmo_s = (state_r == ST_BUSY) && !m_ack && (tmo_cnt_r == TMO_LAST);

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_i_s || gnt_d_s) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (m_ack || tmo_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Access latches, watchdog and completion pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_r   <= OWN_I;
      m_req_r   <= 1'b0;
      m_we_r    <= WE_LOAD;
      m_addr_r  <= '0;
      m_wdata_r <= 32'h0000_0000;
      tmo_cnt_r <= '0;
      i_ready_r <= 1'b0;
      d_ready_r <= 1'b0;
      err_r     <= 1'b0;
      i_rdata_r <= 32'h0000_0000;
      d_rdata_r <= 32'h0000_0000;
    end else begin
      i_ready_r <= 1'b0;
      d_ready_r <= 1'b0;
      err_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tmo_cnt_r <= '0;
          if (gnt_d_s) begin
            owner_r   <= OWN_D;
            m_req_r   <= 1'b1;
            m_we_r    <= d_we;
            m_addr_r  <= d_addr;
            m_wdata_r <= store_data(d_we, d_wdata);
          end else if (gnt_i_s) begin
            owner_r   <= OWN_I;
            m_req_r   <= 1'b1;
            m_we_r    <= WE_LOAD;
            m_addr_r  <= i_addr;
            m_wdata_r <= 32'h0000_0000;
          end else begin
            m_req_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (m_ack || tmo_s) begin
            m_req_r   <= 1'b0;
            tmo_cnt_r <= '0;
            err_r     <= !m_ack;
            if (owner_r == OWN_D) begin
              d_ready_r <= 1'b1;
              d_rdata_r <= m_ack ? m_rdata : DEAD_WORD;
            end else begin
              i_ready_r <= 1'b1;
              i_rdata_r <= m_ack ? m_rdata : DEAD_WORD;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        ST_DONE: begin
          m_req_r <= 1'b0;
        end
        default: begin
          m_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign i_ready = i_ready_r;
  assign d_ready = d_ready_r;
  assign i_rdata = i_rdata_r;
  assign d_rdata = d_rdata_r;
  assign err     = err_r;
  assign m_req   = m_req_r;
  assign m_we    = m_we_r;
  assign m_addr  = m_addr_r;
  assign m_wdata = m_wdata_r;
  assign istall  = i_req & ~i_ready_r;
  assign dstall  = d_req & ~d_ready_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_we;
  logic        i_ready, d_ready, istall, dstall, m_req, err, m_ack;
  logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic [1:0]  m_we;
  logic [31:0] m_addr;
  logic        auto_ack, ack_man;
  logic [31:0] rdata_man;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign m_ack   = auto_ack ? m_req  : ack_man;
  assign m_rdata = auto_ack ? m_addr : rdata_man;

  mem_port_arbiter #(.AW(32), .D_BURST(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .istall(istall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .dstall(dstall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int grants, ir, dr;
    logic [31:0] seen [10];
    logic [31:0] exp_seq [10];

    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; i_addr = 32'h0; d_addr = 32'h0;
    d_wdata = 32'h0; d_we = 2'b00; auto_ack = 1'b0; ack_man = 1'b0; rdata_man = 32'h0;
    tick(); tick();
    chk("rst_m_req",   32'(m_req),   32'h0);
    chk("rst_m_we",    32'(m_we),    32'h0);
    chk("rst_ready",   32'({i_ready, d_ready, err}), 32'h0);
    chk("rst_d_rdata", d_rdata,      32'h0);
    chk("rst_i_rdata", i_rdata,      32'h0);
    reset = 1'b1;
    tick();

    // 1: D load, ack in first BUSY cycle
    d_req = 1'b1; d_we = 2'b00; d_addr = 32'h40; ack_man = 1'b1; rdata_man = 32'h1234_5678;
    #1;
    chk("t1_dstall_c0", 32'(dstall), 32'h1);
    tick();
    chk("t1_m_req_c1",  32'(m_req),   32'h1);
    chk("t1_m_addr",    m_addr,       32'h40);
    chk("t1_dstall_c1", 32'(dstall),  32'h1);
    chk("t1_ready_c1",  32'(d_ready), 32'h0);
    tick();
    chk("t1_ready_c2",  32'(d_ready), 32'h1);
    chk("t1_rdata",     d_rdata,      32'h1234_5678);
    chk("t1_dstall_c2", 32'(dstall),  32'h0);
    chk("t1_err",       32'(err),     32'h0);
    d_req = 1'b0; ack_man = 1'b0;
    tick();
    chk("t1_ready_c3",  32'(d_ready), 32'h0);

    // 3: sb with I waiting
    d_req = 1'b1; d_we = 2'b11; d_addr = 32'h43; d_wdata = 32'hAB;
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    chk("t3_m_req",   32'(m_req),  32'h1);
    chk("t3_m_we",    32'(m_we),   32'h3);
    chk("t3_m_addr",  m_addr,      32'h43);
    chk("t3_m_wdata", m_wdata,     32'h0000_00AB);
    chk("t3_istall",  32'(istall), 32'h1);
    ack_man = 1'b1; rdata_man = 32'h7777_7777;
    tick();
    chk("t3_d_ready", 32'(d_ready), 32'h1);
    chk("t3_istall2", 32'(istall),  32'h1);
    d_req = 1'b0; ack_man = 1'b0;
    tick();
    tick();
    chk("t3_i_m_we",   32'(m_we), 32'h0);
    chk("t3_i_m_addr", m_addr,    32'h100);
    ack_man = 1'b1; rdata_man = 32'hCAFE_0001;
    tick();
    chk("t3_i_ready", 32'(i_ready), 32'h1);
    chk("t3_i_rdata", i_rdata,      32'hCAFE_0001);
    chk("t3_istall3", 32'(istall),  32'h0);
    i_req = 1'b0; ack_man = 1'b0;
    tick();

    // 4: timeout abort, then a normal access
    d_req = 1'b1; d_we = 2'b00; d_addr = 32'h80;
    tick();
    for (int k = 0; k < 15; k++) tick();
    chk("t4_busy16_m_req", 32'(m_req),   32'h1);
    chk("t4_busy16_ready", 32'(d_ready), 32'h0);
    tick();
    chk("t4_ready", 32'(d_ready), 32'h1);
    chk("t4_err",   32'(err),     32'h1);
    chk("t4_rdata", d_rdata,      32'hDEAD_BEEF);
    d_req = 1'b0;
    tick();
    chk("t4_err_low", 32'(err), 32'h0);
    d_req = 1'b1; d_addr = 32'h84; ack_man = 1'b1; rdata_man = 32'h55AA_55AA;
    tick();
    tick();
    chk("t4_next_ready", 32'(d_ready), 32'h1);
    chk("t4_next_rdata", d_rdata,      32'h55AA_55AA);
    chk("t4_next_err",   32'(err),     32'h0);
    d_req = 1'b0; ack_man = 1'b0;
    tick();

    // 6: m_ack coincides with watchdog expiry
    d_req = 1'b1; d_addr = 32'h88;
    tick();
    for (int k = 0; k < 15; k++) tick();
    chk("t6_busy16_m_req", 32'(m_req), 32'h1);
    ack_man = 1'b1; rdata_man = 32'h0BAD_F00D;
    tick();
    chk("t6_ready", 32'(d_ready), 32'h1);
    chk("t6_err",   32'(err),     32'h0);
    chk("t6_rdata", d_rdata,      32'h0BAD_F00D);
    d_req = 1'b0; ack_man = 1'b0;
    tick();

    // 5: reset in second BUSY cycle, then a late ack
    d_req = 1'b1; i_req = 1'b1; d_addr = 32'h90; i_addr = 32'h200;
    tick();
    tick();
    reset = 1'b0; d_req = 1'b0; i_req = 1'b0;
    tick();
    chk("t5_m_req",  32'(m_req), 32'h0);
    chk("t5_ready",  32'({i_ready, d_ready, err}), 32'h0);
    chk("t5_burst",  32'(dut.u_pick.burst_r), 32'h0);
    chk("t5_rdata",  d_rdata, 32'h0);
    reset = 1'b1; ack_man = 1'b1; rdata_man = 32'h1111_1111;
    tick();
    chk("t5_late_ready", 32'({i_ready, d_ready, err}), 32'h0);
    chk("t5_late_m_req", 32'(m_req), 32'h0);
    tick();
    chk("t5_late_ready2", 32'({i_ready, d_ready, err}), 32'h0);
    ack_man = 1'b0;
    tick();

    // 2: both requesters held, auto-ack memory
    exp_seq = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200,
                32'h300, 32'h300, 32'h300, 32'h300, 32'h200};
    auto_ack = 1'b1;
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 2'b00; d_addr = 32'h300;
    grants = 0; ir = 0; dr = 0;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      tick();
      if (i_ready) ir++;
      if (d_ready) begin
        dr++;
        chk("t2_d_rdata", d_rdata, 32'h300);
      end
      if (m_req) begin
        seen[grants] = m_addr;
        grants++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    if (i_ready) ir++;
    if (d_ready) dr++;
    tick();
    chk("t2_grants", 32'(grants), 32'd10);
    for (int g = 0; g < 10; g++) begin
      if (g < grants) chk($sformatf("t2_grant%0d", g), seen[g], exp_seq[g]);
    end
    chk("t2_i_readies", 32'(ir), 32'd2);
    chk("t2_d_readies", 32'(dr), 32'd8);
    auto_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
